// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Brief    : Shared FIFO constants and Gray/binary pointer conversions.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEF_A_WIDTH = 4;
    localparam int DEPTH       = 2 ** DEF_A_WIDTH;
    localparam int PTR_W       = DEF_A_WIDTH + 1;
    localparam int FN_W        = 32;

    typedef logic [PTR_W-1:0] ptr_t;

    // Conversions work on a wide word; callers size-cast in and out.
    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_ptr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_ptr_gen
//  Brief    : Binary/Gray pointer counter with increment enable and
//             registered Gray output; shared by read and write sides.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_ptr_gen
    import fifo_pkg::*;
#(
    parameter int PW = PTR_W
) (
    input  logic          Clk,
    input  logic          Resetn,
    input  logic          inc_i,
    output logic [PW-2:0] addr_o,
    output logic [PW-1:0] bin_next_o,
    output logic [PW-1:0] gray_o,
    output logic [PW-1:0] gray_next_o
);

    logic [PW-1:0] bin_q;
    logic [PW-1:0] bin_d;
    logic [PW-1:0] gray_q;
    logic [PW-1:0] gray_d;

    always_comb begin
        bin_d  = bin_q + {{(PW-1){1'b0}}, inc_i};
        gray_d = PW'(bin2gray(FN_W'(bin_d)));
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    // Address is taken from the current pointer, before this cycle's increment.
    assign addr_o      = bin_q[PW-2:0];
    assign bin_next_o  = bin_d;
    assign gray_o      = gray_q;
    assign gray_next_o = gray_d;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_ctrl
//  Brief    : Async-FIFO read-side controller: pointer, empty/level flags and
//             first-word-fall-through output stage.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int a_width  = DEF_A_WIDTH,
    parameter int AE_LEVEL = 2,
    parameter int DW       = 8
) (
    input  logic               Clk,
    input  logic               Resetn,
    input  logic [a_width:0]   wr_syn_ptr,
    output logic [a_width:0]   rd_ptr,
    output logic               mem_rd_en,
    output logic [a_width-1:0] mem_rd_addr,
    input  logic [DW-1:0]      mem_rd_data,
    output logic [DW-1:0]      dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               empty,
    output logic               almost_empty,
    output logic [a_width:0]   rd_level
);

    localparam int PW = a_width + 1;

    logic          fetch;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic [PW-1:0] wr_bin;

    logic          empty_q, empty_d;
    logic          ae_q, ae_d;
    logic [PW-1:0] level_q, level_d;
    logic          dout_valid_q, dout_valid_d;

    fifo_rd_ptr_gen #(
        .PW (PW)
    ) u_ptr (
        .Clk         (Clk),
        .Resetn      (Resetn),
        .inc_i       (fetch),
        .addr_o      (mem_rd_addr),
        .bin_next_o  (rd_bin_next),
        .gray_o      (rd_ptr),
        .gray_next_o (rd_gray_next)
    );

    // Fetch whenever the output slot is free or being drained this cycle.
    assign fetch     = !empty_q && (!dout_valid_q || dout_ready);
    assign mem_rd_en = fetch;
    assign wr_bin    = PW'(gray2bin(FN_W'(wr_syn_ptr)));

    always_comb begin
        empty_d      = (rd_gray_next == wr_syn_ptr);
        level_d      = wr_bin - rd_bin_next;
        ae_d         = (level_d <= PW'(AE_LEVEL));
        dout_valid_d = dout_valid_q;
        if (fetch) begin
            dout_valid_d = 1'b1;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            empty_q      <= 1'b1;
            ae_q         <= 1'b1;
            level_q      <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            empty_q      <= empty_d;
            ae_q         <= ae_d;
            level_q      <= level_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // The memory output register doubles as the output data stage.
    assign dout         = mem_rd_data;
    assign dout_valid   = dout_valid_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign rd_level     = level_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_ctrl
//  Brief    : Directed self-checking bench for fifo_rd_ctrl (a_width=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

    logic       Clk = 1'b0;
    logic       Resetn = 1'b1;
    logic [4:0] wr_syn_ptr = '0;
    logic       dout_ready = 1'b0;
    logic [7:0] mem_rd_data = '0;
    logic [4:0] rd_ptr;
    logic       mem_rd_en;
    logic [3:0] mem_rd_addr;
    logic [7:0] dout;
    logic       dout_valid;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_level;

    logic [7:0] mem [16];
    int n_cmp = 0;
    int n_err = 0;

    fifo_rd_ctrl #(
        .a_width  (4),
        .AE_LEVEL (2),
        .DW       (8)
    ) dut (
        .Clk          (Clk),
        .Resetn       (Resetn),
        .wr_syn_ptr   (wr_syn_ptr),
        .rd_ptr       (rd_ptr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level)
    );

    always #5 Clk = ~Clk;

    // Registered memory read port.
    always @(posedge Clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        Resetn     = 1'b0;
        dout_ready = 1'b0;
        wr_syn_ptr = '0;
        tick();
        tick();
        Resetn = 1'b1;
    endtask

    task automatic test_reset;
        #3;
        Resetn = 1'b0;
        #1;
        n_cmp++; if (rd_ptr !== 5'd0)     begin n_err++; $display("FAIL reset_rd_ptr: got %b want 00000", rd_ptr); end
        n_cmp++; if (empty !== 1'b1)      begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
        n_cmp++; if (rd_level !== 5'd0)   begin n_err++; $display("FAIL reset_level: got %0d want 0", rd_level); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
        n_cmp++; if (mem_rd_en !== 1'b0)  begin n_err++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
        tick();
        Resetn = 1'b1;
    endtask

    task automatic test_single_word;
        do_reset();
        wr_syn_ptr = 5'b00001;
        tick();
        n_cmp++; if (empty !== 1'b0)       begin n_err++; $display("FAIL sw_empty: got %b want 0", empty); end
        n_cmp++; if (rd_level !== 5'd1)    begin n_err++; $display("FAIL sw_level: got %0d want 1", rd_level); end
        n_cmp++; if (mem_rd_en !== 1'b1)   begin n_err++; $display("FAIL sw_fetch: got %b want 1", mem_rd_en); end
        n_cmp++; if (mem_rd_addr !== 4'd0) begin n_err++; $display("FAIL sw_addr: got %0d want 0", mem_rd_addr); end
        tick();
        n_cmp++; if (dout_valid !== 1'b1)  begin n_err++; $display("FAIL sw_valid: got %b want 1", dout_valid); end
        n_cmp++; if (rd_ptr !== 5'b00001)  begin n_err++; $display("FAIL sw_rd_ptr: got %b want 00001", rd_ptr); end
        n_cmp++; if (dout !== 8'hA0)       begin n_err++; $display("FAIL sw_dout: got %h want a0", dout); end
        n_cmp++; if (empty !== 1'b1)       begin n_err++; $display("FAIL sw_empty2: got %b want 1", empty); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (dout_valid !== 1'b1 || dout !== 8'hA0 || mem_rd_en !== 1'b0)
                begin n_err++; $display("FAIL sw_hold: valid=%b dout=%h en=%b want 1/a0/0", dout_valid, dout, mem_rd_en); end
        end
        dout_ready = 1'b1;
        tick();
        n_cmp++; if (dout_valid !== 1'b0)  begin n_err++; $display("FAIL sw_drain: got %b want 0", dout_valid); end
    endtask

    task automatic test_streaming;
        int rb;
        int beats;
        beats = 0;
        do_reset();
        dout_ready = 1'b1;
        wr_syn_ptr = 5'b01100;
        for (int i = 1; i <= 10; i++) begin
            tick();
            rb = (i - 1 > 8) ? 8 : i - 1;
            n_cmp++; if (rd_level !== 5'(8 - rb)) begin n_err++; $display("FAIL st_level[%0d]: got %0d want %0d", i, rd_level, 8 - rb); end
            n_cmp++; if (almost_empty !== ((8 - rb) <= 2)) begin n_err++; $display("FAIL st_ae[%0d]: got %b want %b", i, almost_empty, (8 - rb) <= 2); end
            n_cmp++; if (empty !== (rb == 8)) begin n_err++; $display("FAIL st_empty[%0d]: got %b want %b", i, empty, rb == 8); end
            n_cmp++; if (mem_rd_en !== (rb < 8)) begin n_err++; $display("FAIL st_en[%0d]: got %b want %b", i, mem_rd_en, rb < 8); end
            if (rb < 8) begin
                n_cmp++; if (mem_rd_addr !== 4'(rb)) begin n_err++; $display("FAIL st_addr[%0d]: got %0d want %0d", i, mem_rd_addr, rb); end
            end
            n_cmp++; if (dout_valid !== (i >= 2 && i <= 9)) begin n_err++; $display("FAIL st_valid[%0d]: got %b want %b", i, dout_valid, i >= 2 && i <= 9); end
            if (dout_valid === 1'b1) begin
                n_cmp++; if (dout !== 8'(8'hA0 + beats)) begin n_err++; $display("FAIL st_dout[%0d]: got %h want %h", i, dout, 8'(8'hA0 + beats)); end
                beats++;
            end
        end
        n_cmp++; if (beats != 8) begin n_err++; $display("FAIL st_beats: got %0d want 8", beats); end
    endtask

    task automatic test_backpressure;
        logic [3:0] pat;
        int got;
        logic stalled;
        logic [7:0] held;
        pat = 4'b1001;
        got = 0;
        stalled = 1'b0;
        held = '0;
        do_reset();
        wr_syn_ptr = 5'b01100;
        for (int c = 0; c < 40; c++) begin
            tick();
            dout_ready = pat[c % 4];
            #1;
            if (stalled) begin
                n_cmp++; if (dout_valid !== 1'b1 || dout !== held)
                    begin n_err++; $display("FAIL bp_stable[%0d]: valid=%b dout=%h want 1/%h", c, dout_valid, dout, held); end
            end
            if (dout_valid && !dout_ready) begin
                n_cmp++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_nofetch[%0d]: got %b want 0", c, mem_rd_en); end
            end
            if (dout_valid && dout_ready) begin
                n_cmp++; if (dout !== 8'(8'hA0 + got)) begin n_err++; $display("FAIL bp_word[%0d]: got %h want %h", got, dout, 8'(8'hA0 + got)); end
                got++;
            end
            stalled = dout_valid && !dout_ready;
            held    = dout;
        end
        n_cmp++; if (got != 8) begin n_err++; $display("FAIL bp_count: got %0d want 8", got); end
        n_cmp++; if (empty !== 1'b1 || dout_valid !== 1'b0)
            begin n_err++; $display("FAIL bp_end: empty=%b valid=%b want 1/0", empty, dout_valid); end
    endtask

    task automatic test_reset_mid_stream;
        do_reset();
        wr_syn_ptr = 5'b01100;
        tick();
        tick();
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre_valid: got %b want 1", dout_valid); end
        #2;
        Resetn = 1'b0;
        #1;
        n_cmp++; if (dout_valid !== 1'b0 || empty !== 1'b1 || rd_ptr !== 5'd0 || rd_level !== 5'd0 || almost_empty !== 1'b1)
            begin n_err++; $display("FAIL rm_clear: valid=%b empty=%b ptr=%b lvl=%0d ae=%b want 0/1/0/0/1",
                                    dout_valid, empty, rd_ptr, rd_level, almost_empty); end
        tick();
        wr_syn_ptr = '0;
        Resetn = 1'b1;
    endtask

    task automatic test_wrap;
        logic [3:0] wexp [4];
        int n_addr;
        logic [4:0] prev;
        wexp = '{4'd14, 4'd15, 4'd0, 4'd1};
        n_addr = 0;
        do_reset();
        dout_ready = 1'b1;
        wr_syn_ptr = 5'b01001;
        repeat (20) tick();
        n_cmp++; if (rd_ptr !== 5'b01001 || empty !== 1'b1 || dout_valid !== 1'b0)
            begin n_err++; $display("FAIL wr_preload: ptr=%b empty=%b valid=%b want 01001/1/0", rd_ptr, empty, dout_valid); end
        prev = rd_ptr;
        wr_syn_ptr = 5'b11011;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) begin
                n_cmp++; if (rd_level !== 5'd4) begin n_err++; $display("FAIL wr_level4: got %0d want 4", rd_level); end
            end
            n_cmp++; if ($countones(rd_ptr ^ prev) > 1) begin n_err++; $display("FAIL wr_gray_step: %b -> %b", prev, rd_ptr); end
            prev = rd_ptr;
            if (mem_rd_en) begin
                if (n_addr < 4) begin
                    n_cmp++; if (mem_rd_addr !== wexp[n_addr]) begin n_err++; $display("FAIL wr_addr[%0d]: got %0d want %0d", n_addr, mem_rd_addr, wexp[n_addr]); end
                end
                n_addr++;
            end
        end
        n_cmp++; if (n_addr != 4) begin n_err++; $display("FAIL wr_addr_count: got %0d want 4", n_addr); end
        n_cmp++; if (rd_ptr !== 5'b11011 || rd_level !== 5'd0 || empty !== 1'b1)
            begin n_err++; $display("FAIL wr_end: ptr=%b lvl=%0d empty=%b want 11011/0/1", rd_ptr, rd_level, empty); end
    endtask

    task automatic test_full_depth;
        int got;
        got = 0;
        dout_ready = 1'b0;
        wr_syn_ptr = 5'b00011;
        tick();
        n_cmp++; if (rd_level !== 5'd16) begin n_err++; $display("FAIL fd_level: got %0d want 16", rd_level); end
        n_cmp++; if (almost_empty !== 1'b0 || empty !== 1'b0)
            begin n_err++; $display("FAIL fd_flags: ae=%b empty=%b want 0/0", almost_empty, empty); end
        dout_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dout_valid) begin
                n_cmp++; if (dout !== 8'(8'hA0 + ((2 + got) % 16))) begin n_err++; $display("FAIL fd_word[%0d]: got %h want %h", got, dout, 8'(8'hA0 + ((2 + got) % 16))); end
                got++;
            end
        end
        n_cmp++; if (got != 16) begin n_err++; $display("FAIL fd_count: got %0d want 16", got); end
        n_cmp++; if (empty !== 1'b1 || rd_level !== 5'd0)
            begin n_err++; $display("FAIL fd_end: empty=%b lvl=%0d want 1/0", empty, rd_level); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_reset_mid_stream();
        test_wrap();
        test_full_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
